// File: rtl/pmp_csr_file.sv
// Machine-mode PMP CSR storage (pmpcfg0-3, pmpaddr0-15) with lock, TOR-lock and WARL
// handling, served through a one-cycle req/ack handshake.
module pmp_csr_file #(
  parameter logic [11:0] CFG_BASE  = 12'h3A0,
  parameter logic [11:0] ADDR_BASE = 12'h3B0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [1:0]  priv_mode,
  output logic        csr_ack,
  output logic        csr_illegal,
  output logic [31:0] csr_rdata,
  output logic [31:0] pmpcfg0_data,
  output logic [31:0] pmpcfg1_data,
  output logic [31:0] pmpcfg2_data,
  output logic [31:0] pmpcfg3_data,
  output logic [31:0] pmpaddr0_data,
  output logic [31:0] pmpaddr1_data,
  output logic [31:0] pmpaddr2_data,
  output logic [31:0] pmpaddr3_data,
  output logic [31:0] pmpaddr4_data,
  output logic [31:0] pmpaddr5_data,
  output logic [31:0] pmpaddr6_data,
  output logic [31:0] pmpaddr7_data,
  output logic [31:0] pmpaddr8_data,
  output logic [31:0] pmpaddr9_data,
  output logic [31:0] pmpaddr10_data,
  output logic [31:0] pmpaddr11_data,
  output logic [31:0] pmpaddr12_data,
  output logic [31:0] pmpaddr13_data,
  output logic [31:0] pmpaddr14_data,
  output logic [31:0] pmpaddr15_data
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cfg_q  [16];
  logic [7:0]  cfg_d  [16];
  logic [31:0] addr_q [16];
  logic [31:0] addr_d [16];
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;

  logic [11:0] cfg_off, addr_off;
  logic        is_cfg, is_addr, illegal, accept, wr_en;
  logic [31:0] old_val, new_val;

  assign accept = (state_q == IDLE) && csr_req;
  assign wr_en  = accept && !illegal && (csr_op != 2'b00);

  always_comb begin
    cfg_off  = csr_addr - CFG_BASE;
    addr_off = csr_addr - ADDR_BASE;
    is_cfg   = cfg_off < 12'd4;
    is_addr  = addr_off < 12'd16;
    illegal  = (priv_mode != 2'b11) || !(is_cfg || is_addr);
    old_val  = '0;
    if (is_cfg) begin
      old_val = {cfg_q[{cfg_off[1:0], 2'd3}], cfg_q[{cfg_off[1:0], 2'd2}],
                 cfg_q[{cfg_off[1:0], 2'd1}], cfg_q[{cfg_off[1:0], 2'd0}]};
    end else if (is_addr) begin
      old_val = addr_q[addr_off[3:0]];
    end
    case (csr_op)
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = csr_wdata;
    endcase
  end

  // Lock checks below always look at cfg_q, i.e. the locks held before this access.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_entry
      localparam int B = 8 * (gi % 4);
      logic cfg_wr;
      logic addr_lock;

      assign cfg_wr = wr_en && is_cfg && (cfg_off[1:0] == 2'(gi / 4)) && !cfg_q[gi][7];
      // Reserved bits forced to zero; W survives only together with R.
      assign cfg_d[gi] = cfg_wr ? {new_val[B+7], 2'b00, new_val[B+2 +: 3],
                                   new_val[B+1] & new_val[B], new_val[B]}
                                : cfg_q[gi];

      if (gi < 15) begin : g_tor
        assign addr_lock = cfg_q[gi][7] || (cfg_q[gi+1][7] && (cfg_q[gi+1][4:3] == 2'b01));
      end else begin : g_last
        assign addr_lock = cfg_q[gi][7];
      end

      assign addr_d[gi] = (wr_en && is_addr && !is_cfg && (addr_off[3:0] == 4'(gi)) && !addr_lock)
                          ? new_val : addr_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csr_req) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_ack   = (state_q == RESP);
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    if (accept) begin
      rdata_d   = illegal ? 32'h0 : old_val;
      illegal_d = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= cfg_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign csr_rdata      = rdata_q;
  assign csr_illegal    = illegal_q;
  assign pmpcfg0_data   = {cfg_q[3],  cfg_q[2],  cfg_q[1],  cfg_q[0]};
  assign pmpcfg1_data   = {cfg_q[7],  cfg_q[6],  cfg_q[5],  cfg_q[4]};
  assign pmpcfg2_data   = {cfg_q[11], cfg_q[10], cfg_q[9],  cfg_q[8]};
  assign pmpcfg3_data   = {cfg_q[15], cfg_q[14], cfg_q[13], cfg_q[12]};
  assign pmpaddr0_data  = addr_q[0];
  assign pmpaddr1_data  = addr_q[1];
  assign pmpaddr2_data  = addr_q[2];
  assign pmpaddr3_data  = addr_q[3];
  assign pmpaddr4_data  = addr_q[4];
  assign pmpaddr5_data  = addr_q[5];
  assign pmpaddr6_data  = addr_q[6];
  assign pmpaddr7_data  = addr_q[7];
  assign pmpaddr8_data  = addr_q[8];
  assign pmpaddr9_data  = addr_q[9];
  assign pmpaddr10_data = addr_q[10];
  assign pmpaddr11_data = addr_q[11];
  assign pmpaddr12_data = addr_q[12];
  assign pmpaddr13_data = addr_q[13];
  assign pmpaddr14_data = addr_q[14];
  assign pmpaddr15_data = addr_q[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed bench for pmp_csr_file: handshake timing, lock/TOR-lock/WARL rules,
// illegal accesses and reset during a pending response.
module tb_pmp_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  priv_mode;
  logic        csr_ack;
  logic        csr_illegal;
  logic [31:0] csr_rdata;
  logic [31:0] cfg_o  [4];
  logic [31:0] addr_o [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pmp_csr_file dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .priv_mode(priv_mode),
    .csr_ack(csr_ack), .csr_illegal(csr_illegal), .csr_rdata(csr_rdata),
    .pmpcfg0_data(cfg_o[0]), .pmpcfg1_data(cfg_o[1]),
    .pmpcfg2_data(cfg_o[2]), .pmpcfg3_data(cfg_o[3]),
    .pmpaddr0_data(addr_o[0]),   .pmpaddr1_data(addr_o[1]),
    .pmpaddr2_data(addr_o[2]),   .pmpaddr3_data(addr_o[3]),
    .pmpaddr4_data(addr_o[4]),   .pmpaddr5_data(addr_o[5]),
    .pmpaddr6_data(addr_o[6]),   .pmpaddr7_data(addr_o[7]),
    .pmpaddr8_data(addr_o[8]),   .pmpaddr9_data(addr_o[9]),
    .pmpaddr10_data(addr_o[10]), .pmpaddr11_data(addr_o[11]),
    .pmpaddr12_data(addr_o[12]), .pmpaddr13_data(addr_o[13]),
    .pmpaddr14_data(addr_o[14]), .pmpaddr15_data(addr_o[15])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++)  check($sformatf("%s_cfg%0d", tag, i), cfg_o[i], 32'h0);
    for (int i = 0; i < 16; i++) check($sformatf("%s_addr%0d", tag, i), addr_o[i], 32'h0);
  endtask

  // One full transaction: ack must be low before acceptance, high right after, low again next cycle.
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [1:0] pm, output logic [31:0] rd, output logic ill);
    @(negedge clk);
    check("ack_idle", {31'h0, csr_ack}, 32'h0);
    csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd; priv_mode = pm;
    @(posedge clk); #1;
    check("ack_pulse", {31'h0, csr_ack}, 32'h1);
    rd  = csr_rdata;
    ill = csr_illegal;
    csr_req = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {31'h0, csr_ack}, 32'h0);
    $display("txn op=%0d addr=%03h wdata=%08h priv=%0d -> rdata=%08h illegal=%0d",
             op, addr, wd, pm, rd, ill);
  endtask

  logic [31:0] rd;
  logic        ill;

  initial begin
    rst_n = 1'b0; csr_req = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0; priv_mode = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, csr_ack}, 32'h0);
    check("rst_ill", {31'h0, csr_illegal}, 32'h0);
    check("rst_rdata", csr_rdata, 32'h0);
    check_all_zero("rst");
    @(negedge clk) rst_n = 1'b1;

    csr_access(2'b00, 12'h3A0, 32'h0, 2'b11, rd, ill);
    check("rd_cfg0", rd, 32'h0);        check("rd_cfg0_ill", {31'h0, ill}, 32'h0);
    csr_access(2'b00, 12'h3BF, 32'h0, 2'b11, rd, ill);
    check("rd_addr15", rd, 32'h0);      check("rd_addr15_ill", {31'h0, ill}, 32'h0);

    // Reserved bits of byte1 cleared, byte0 kept as written.
    csr_access(2'b01, 12'h3A0, 32'h0000_6F0F, 2'b11, rd, ill);
    check("wr_cfg0_old", rd, 32'h0);
    check("wr_cfg0_val", cfg_o[0], 32'h0000_0F0F);

    // W without R is dropped; L locks entry 0 and its address.
    csr_access(2'b01, 12'h3A0, 32'h0000_0082, 2'b11, rd, ill);
    check("warl_old", rd, 32'h0000_0F0F);
    check("warl_val", cfg_o[0], 32'h0000_0080);
    csr_access(2'b01, 12'h3B0, 32'h1234_5678, 2'b11, rd, ill);
    check("lock_addr0_ill", {31'h0, ill}, 32'h0);
    check("lock_addr0", addr_o[0], 32'h0);

    // Set cfg1 = L|TOR|R while byte0 stays locked.
    csr_access(2'b10, 12'h3A0, 32'h0000_8900, 2'b11, rd, ill);
    check("set_cfg0_old", rd, 32'h0000_0080);
    check("set_cfg0_val", cfg_o[0], 32'h0000_8980);
    csr_access(2'b01, 12'h3B0, 32'h0000_1000, 2'b11, rd, ill);
    check("tor_addr0", addr_o[0], 32'h0);
    csr_access(2'b01, 12'h3B1, 32'h0000_2000, 2'b11, rd, ill);
    check("tor_addr1", addr_o[1], 32'h0);
    csr_access(2'b01, 12'h3B2, 32'h0000_3000, 2'b11, rd, ill);
    check("wr_addr2", addr_o[2], 32'h0000_3000);
    csr_access(2'b10, 12'h3B2, 32'h0000_0001, 2'b11, rd, ill);
    check("set_addr2_old", rd, 32'h0000_3000);
    check("set_addr2_val", addr_o[2], 32'h0000_3001);

    // Clear R of an R|W byte: WARL then drops W too.
    csr_access(2'b01, 12'h3A1, 32'h0000_0003, 2'b11, rd, ill);
    check("wr_cfg1_val", cfg_o[1], 32'h0000_0003);
    csr_access(2'b11, 12'h3A1, 32'h0000_0001, 2'b11, rd, ill);
    check("clr_cfg1_old", rd, 32'h0000_0003);
    check("clr_cfg1_val", cfg_o[1], 32'h0000_0000);
    csr_access(2'b00, 12'h3A0, 32'hFFFF_FFFF, 2'b11, rd, ill);
    check("rd_cfg0_back", rd, 32'h0000_8980);
    check("rd_no_change", cfg_o[0], 32'h0000_8980);

    // Illegal accesses: wrong privilege, unmapped address.
    csr_access(2'b01, 12'h3B5, 32'hDEAD_BEEF, 2'b00, rd, ill);
    check("umode_ill", {31'h0, ill}, 32'h1);
    check("umode_rdata", rd, 32'h0);
    check("umode_addr5", addr_o[5], 32'h0);
    csr_access(2'b01, 12'h3A7, 32'hFFFF_FFFF, 2'b11, rd, ill);
    check("bad_addr_ill", {31'h0, ill}, 32'h1);
    check("bad_addr_rdata", rd, 32'h0);
    check("bad_addr_cfg0", cfg_o[0], 32'h0000_8980);
    check("bad_addr_cfg1", cfg_o[1], 32'h0);

    // Reset while the response is pending, then a held request after release.
    @(negedge clk);
    csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h3B3; csr_wdata = 32'h0000_ABCD; priv_mode = 2'b11;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstresp_ack", {31'h0, csr_ack}, 32'h0);
    check("rstresp_rdata", csr_rdata, 32'h0);
    check_all_zero("rstresp");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("held_ack1", {31'h0, csr_ack}, 32'h1);
    check("held_rdata1", csr_rdata, 32'h0);
    check("held_addr3", addr_o[3], 32'h0000_ABCD);
    $display("txn held write addr=3b3 first accept rdata=%08h", csr_rdata);
    @(posedge clk); #1;
    check("held_ack_resp", {31'h0, csr_ack}, 32'h0);
    @(posedge clk); #1;
    check("held_ack2", {31'h0, csr_ack}, 32'h1);
    check("held_rdata2", csr_rdata, 32'h0000_ABCD);
    $display("txn held write addr=3b3 second accept rdata=%08h", csr_rdata);
    @(negedge clk) csr_req = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
